// File: rtl/snake_motion_engine.sv
// snake_motion_engine: snake body state, head advance, apple/wall/self collision detection
module snake_motion_engine #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 9,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 143
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       tick,
  input  logic [3:0] direction,
  input  logic [3:0] apple_x,
  input  logic [3:0] apple_y,
  input  logic       apple_valid,
  output logic       goodColl,
  output logic       badColl,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [7:0] length,
  output logic       busy,
  output logic       alive
);
  typedef enum logic [2:0] {IDLE, RUN, CHECK, COMMIT, DEAD} state_t;
  localparam logic [1:0] RIGHT = 2'd0, LEFT = 2'd1, DOWN = 2'd2, UP = 2'd3;
  state_t state;
  logic [1:0] cur_dir, pend_dir, req;
  logic req_v, opp, eat, hit, wall, match;
  logic [3:0] bx [MAX_LEN];
  logic [3:0] by [MAX_LEN];
  logic [4:0] nxt_x, nxt_y, nx_c, ny_c;
  logic [7:0] idx, lim;
  assign head_x = bx[0];
  assign head_y = by[0];
  assign busy = state == CHECK || state == COMMIT;
  assign alive = state == RUN || state == CHECK || state == COMMIT;
  // direction priority, reversal test, candidate head and scan bookkeeping
  always_comb begin
    req_v = |direction;
    req = direction[3] ? UP : direction[2] ? DOWN : direction[1] ? LEFT : RIGHT;
    opp = {req[1], ~req[0]} == cur_dir;
    nx_c = pend_dir == RIGHT ? {1'b0, head_x} + 5'd1 : pend_dir == LEFT ? {1'b0, head_x} - 5'd1 : {1'b0, head_x};
    ny_c = pend_dir == DOWN ? {1'b0, head_y} + 5'd1 : pend_dir == UP ? {1'b0, head_y} - 5'd1 : {1'b0, head_y};
    wall = nxt_x >= 5'(GRID_W) || nxt_y >= 5'(GRID_H);
    lim = eat ? length : length - 8'd1;
    match = {1'b0, bx[idx]} == nxt_x && {1'b0, by[idx]} == nxt_y;
  end
  // move FSM: latch direction, scan body one segment per cycle, commit or die
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      cur_dir <= RIGHT;
      pend_dir <= RIGHT;
      length <= 8'(INIT_LEN);
      goodColl <= 1'b0;
      badColl <= 1'b0;
      nxt_x <= 5'd0;
      nxt_y <= 5'd0;
      eat <= 1'b0;
      hit <= 1'b0;
      idx <= 8'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        bx[i] <= i < INIT_LEN ? 4'(4 - i) : 4'd0;
        by[i] <= 4'd4;
      end
    end else begin
      goodColl <= 1'b0;
      badColl <= 1'b0;
      if (req_v && !opp) pend_dir <= req;
      case (state)
        IDLE: if (req_v) state <= RUN;
        RUN: if (tick) begin
          cur_dir <= pend_dir;
          nxt_x <= nx_c;
          nxt_y <= ny_c;
          eat <= apple_valid && nx_c == {1'b0, apple_x} && ny_c == {1'b0, apple_y};
          idx <= 8'd0;
          hit <= 1'b0;
          state <= CHECK;
        end
        CHECK: if (wall || match) begin
          hit <= 1'b1;
          state <= COMMIT;
        end else begin
          idx <= idx + 8'd1;
          if (idx + 8'd1 == lim) state <= COMMIT;
        end
        COMMIT: if (hit) begin
          badColl <= 1'b1;
          state <= DEAD;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            bx[i] <= bx[i-1];
            by[i] <= by[i-1];
          end
          bx[0] <= nxt_x[3:0];
          by[0] <= nxt_y[3:0];
          goodColl <= eat;
          if (eat && length < 8'(MAX_LEN)) length <= length + 8'd1;
          state <= RUN;
        end
        DEAD: if (req_v) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            bx[i] <= i < INIT_LEN ? 4'(4 - i) : 4'd0;
            by[i] <= 4'd4;
          end
          length <= 8'(INIT_LEN);
          cur_dir <= RIGHT;
          pend_dir <= req == LEFT ? RIGHT : req;
          state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_motion_engine.sv
// tb_snake_motion_engine: directed and random moves checked against a queue-based snake model
module tb_snake_motion_engine;
  logic clk = 0, nRst = 0, tick = 0, apple_valid = 0;
  logic [3:0] direction = 0, apple_x = 0, apple_y = 0;
  logic goodColl, badColl, busy, alive;
  logic [3:0] head_x, head_y;
  logic [7:0] length;
  int n_chk = 0, n_bad = 0;
  int mx[$], my[$];
  int mlen, mcur, mpend, mst;
  int dx[4] = '{1, -1, 0, 0};
  int dy[4] = '{0, 0, 1, -1};

  snake_motion_engine dut (
    .clk(clk), .nRst(nRst), .tick(tick), .direction(direction),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .goodColl(goodColl), .badColl(badColl), .head_x(head_x), .head_y(head_y),
    .length(length), .busy(busy), .alive(alive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    mx = '{4, 3, 2};
    my = '{4, 4, 4};
    mlen = 3;
    mcur = 0;
    mpend = 0;
    mst = 0;
  endtask

  task automatic m_dir(input logic [3:0] d);
    int r;
    if (d == 0) return;
    r = d[3] ? 3 : d[2] ? 2 : d[1] ? 1 : 0;
    if (mst == 2) begin
      m_reset();
      mpend = (r == 1) ? 0 : r;
      mst = 1;
    end else begin
      if (r != (mcur ^ 1)) mpend = r;
      if (mst == 0) mst = 1;
    end
  endtask

  task automatic m_move(input int ax, input int ay, input bit av, output int lat, output int g, output int b);
    int nx, ny, lim, k;
    bit eat;
    g = 0;
    b = 0;
    lat = 1;
    if (mst != 1) return;
    mcur = mpend;
    nx = mx[0] + dx[mcur];
    ny = my[0] + dy[mcur];
    eat = av && nx == ax && ny == ay;
    if (nx < 0 || nx >= 16 || ny < 0 || ny >= 9) begin
      lat = 3;
      b = 1;
      mst = 2;
      return;
    end
    lim = eat ? mlen : mlen - 1;
    k = 0;
    while (k < lim && !(mx[k] == nx && my[k] == ny)) k++;
    if (k < lim) begin
      lat = k + 3;
      b = 1;
      mst = 2;
      return;
    end
    lat = lim + 2;
    mx.push_front(nx);
    my.push_front(ny);
    if (eat) begin
      g = 1;
      if (mlen < 143) mlen++;
    end
    while (mx.size() > mlen) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".hx"}, head_x, mx[0]);
    check({tag, ".hy"}, head_y, my[0]);
    check({tag, ".len"}, length, mlen);
    check({tag, ".alive"}, alive, mst == 1);
    check({tag, ".busy"}, busy, 0);
  endtask

  task automatic do_reset();
    nRst = 0;
    @(negedge clk);
    nRst = 1;
    m_reset();
    check_state("rst");
    check("rst.pulse", {goodColl, badColl}, 0);
  endtask

  task automatic pulse_dir(input logic [3:0] d);
    direction = d;
    @(negedge clk);
    direction = 0;
    m_dir(d);
    check_state("dir");
  endtask

  task automatic do_tick(input logic [3:0] ax, input logic [3:0] ay, input bit av, input bit extra);
    int elat, eg, eb, edges, bsy, g, b;
    apple_x = ax;
    apple_y = ay;
    apple_valid = av;
    tick = 1;
    @(negedge clk);
    tick = 0;
    apple_x = 4'($urandom);
    apple_y = 4'($urandom);
    m_move(ax, ay, av, elat, eg, eb);
    edges = 1;
    bsy = 0;
    g = 0;
    b = 0;
    while (edges < 400) begin
      if (goodColl) g++;
      if (badColl) b++;
      if (!busy) break;
      bsy++;
      tick = extra && edges == 1;
      @(negedge clk);
      tick = 0;
      edges++;
    end
    check("mv.lat", edges, elat);
    check("mv.good", g, eg);
    check("mv.bad", b, eb);
    check("mv.busy_cycles", bsy, elat - 1);
    check_state("mv");
    @(negedge clk);
    check("mv.pulse_width", {goodColl, badColl}, 0);
  endtask

  initial begin
    int nx, ny, r;
    m_reset();
    repeat (2) @(negedge clk);
    check("por.busy", busy, 0);
    check("por.alive", alive, 0);
    nRst = 1;
    check_state("por");
    // normal move
    pulse_dir(4'b0001);
    do_tick(4'd10, 4'd0, 1, 0);
    check("normal.hx", head_x, 5);
    // eat, then tail follows
    do_reset();
    pulse_dir(4'b0001);
    do_tick(4'd5, 4'd4, 1, 0);
    check("eat.len", length, 4);
    do_tick(4'd10, 4'd0, 1, 0);
    check("eat.tail", mx[3], 3);
    // wall
    do_reset();
    pulse_dir(4'b0001);
    repeat (11) do_tick(4'd0, 4'd0, 0, 0);
    check("wall.hx", head_x, 15);
    do_tick(4'd0, 4'd0, 0, 0);
    // reversal and priority
    do_reset();
    pulse_dir(4'b0001);
    do_tick(4'd0, 4'd0, 0, 0);
    pulse_dir(4'b0010);
    do_tick(4'd0, 4'd0, 0, 0);
    check("rev.hx", head_x, 6);
    pulse_dir(4'b1100);
    do_tick(4'd0, 4'd0, 0, 0);
    check("prio.hy", head_y, 3);
    // self hit
    do_reset();
    pulse_dir(4'b0001);
    do_tick(4'd5, 4'd4, 1, 0);
    do_tick(4'd6, 4'd4, 1, 0);
    pulse_dir(4'b0100);
    do_tick(4'd0, 4'd0, 0, 0);
    pulse_dir(4'b0010);
    do_tick(4'd0, 4'd0, 0, 0);
    pulse_dir(4'b1000);
    do_tick(4'd0, 4'd0, 0, 0);
    check("self.dead", alive, 0);
    pulse_dir(4'b0001);
    check("self.restart_len", length, 3);
    // dropped tick during busy
    do_tick(4'd0, 4'd0, 0, 1);
    // async reset mid-CHECK
    apple_valid = 0;
    tick = 1;
    @(negedge clk);
    tick = 0;
    check("ar.busy_before", busy, 1);
    #2 nRst = 0;
    #1;
    check("ar.busy", busy, 0);
    check("ar.hx", head_x, 4);
    check("ar.len", length, 3);
    check("ar.alive", alive, 0);
    check("ar.pulse", {goodColl, badColl}, 0);
    @(negedge clk);
    nRst = 1;
    m_reset();
    repeat (4) begin
      @(negedge clk);
      check("ar.quiet", {goodColl, badColl, busy}, 0);
    end
    check_state("ar");
    // random traffic
    repeat (250) begin
      r = $urandom_range(0, 9);
      if (r < 3) pulse_dir(4'($urandom_range(0, 15)));
      else begin
        nx = mx[0] + dx[mpend];
        ny = my[0] + dy[mpend];
        if (r < 7 && nx >= 0 && nx < 16 && ny >= 0 && ny < 9)
          do_tick(4'(nx), 4'(ny), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        else
          do_tick(4'($urandom), 4'($urandom_range(0, 8)), $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      end
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
